// File: rtl/captura_jogada_if.sv
// Play-capture bus between the button front end and the game control unit.
interface captura_jogada_if #(
  parameter int unsigned N_BOTOES = 4
);
  logic [N_BOTOES-1:0] botoes;
  logic                habilita;
  logic                zera_jogada;
  logic [N_BOTOES-1:0] jogada;
  logic                jogada_feita;
  logic                jogada_invalida;
  logic                botao_ativo;
  logic [2:0]          db_estado;

  modport master (
    output botoes, habilita, zera_jogada,
    input  jogada, jogada_feita, jogada_invalida, botao_ativo, db_estado
  );

  modport slave (
    input  botoes, habilita, zera_jogada,
    output jogada, jogada_feita, jogada_invalida, botao_ativo, db_estado
  );
endinterface

// File: rtl/captura_jogada.sv
// Synchronises and debounces the raw buttons and hands one clean one-hot play
// per physical press to the game control unit while the play window is open.
module captura_jogada #(
  parameter int unsigned N_BOTOES        = 4,
  parameter int unsigned DEBOUNCE_CICLOS = 50000,
  parameter int unsigned W_CONT          = 16
) (
  input  logic             clock,
  input  logic             reset,
  captura_jogada_if.slave  io
);

  localparam logic [W_CONT-1:0] CNT_ALVO = W_CONT'(DEBOUNCE_CICLOS);
  localparam logic [W_CONT-1:0] CNT_UM   = W_CONT'(1);

  typedef enum logic [2:0] {
    OCIOSO          = 3'd0,
    DEBOUNCE        = 3'd1,
    ACEITA          = 3'd2,
    INVALIDA        = 3'd3,
    ESPERA_SOLTAR   = 3'd4,
    DEBOUNCE_SOLTAR = 3'd5
  } estado_t;

  estado_t             estado_q;
  logic [N_BOTOES-1:0] sync1_q;
  logic [N_BOTOES-1:0] s_q;
  logic [N_BOTOES-1:0] cap_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic [W_CONT-1:0]   cnt_q;

  logic                s_ativo;
  logic                cnt_fim;
  logic [W_CONT-1:0]   cnt_inc;
  logic                cap_onehot;
  logic                aceita_c;

  assign s_ativo    = (s_q != '0);
  assign cnt_fim    = (cnt_q == CNT_ALVO);
  // Saturating increment so the counter can never wrap back to a small value.
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_UM;
  assign cap_onehot = (cap_q != '0) && ((cap_q & (cap_q - N_BOTOES'(1))) == '0);
  assign aceita_c   = (estado_q == DEBOUNCE) && io.habilita && (s_q == cap_q)
                      && cnt_fim && cap_onehot;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      sync1_q  <= '0;
      s_q      <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
      jogada_q <= '0;
    end else begin
      sync1_q <= io.botoes;
      s_q     <= sync1_q;

      // A load on the accepting edge wins over a simultaneous clear.
      if (aceita_c)            jogada_q <= cap_q;
      else if (io.zera_jogada) jogada_q <= '0;

      unique case (estado_q)
        OCIOSO: begin
          if (s_ativo && io.habilita) begin
            estado_q <= DEBOUNCE;
            cap_q    <= s_q;
            cnt_q    <= CNT_UM;
          end else if (s_ativo) begin
            estado_q <= ESPERA_SOLTAR;
          end
        end
        DEBOUNCE: begin
          if (!io.habilita || !s_ativo) begin
            estado_q <= OCIOSO;
          end else if (s_q != cap_q) begin
            cap_q <= s_q;
            cnt_q <= CNT_UM;
          end else if (cnt_fim) begin
            estado_q <= cap_onehot ? ACEITA : INVALIDA;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ACEITA, INVALIDA: estado_q <= ESPERA_SOLTAR;
        ESPERA_SOLTAR: begin
          if (!s_ativo) begin
            estado_q <= DEBOUNCE_SOLTAR;
            cnt_q    <= CNT_UM;
          end
        end
        DEBOUNCE_SOLTAR: begin
          if (s_ativo)      estado_q <= ESPERA_SOLTAR;
          else if (cnt_fim) estado_q <= OCIOSO;
          else              cnt_q    <= cnt_inc;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign io.jogada          = jogada_q;
  assign io.jogada_feita    = (estado_q == ACEITA);
  assign io.jogada_invalida = (estado_q == INVALIDA);
  assign io.botao_ativo     = s_ativo;
  assign io.db_estado       = estado_q;

endmodule

// File: doc/captura_jogada.md
Name: captura_jogada

Overview:
- Player-side input front end for the memory game.
- Synchronises and debounces the raw push-buttons and rejects multi-button presses.
- Delivers one clean, registered one-hot play with a single-cycle `jogada_feita` strobe to the game control unit.
- Only accepts presses while the control unit opens a play window (`habilita`, driven from `vez_jogador`/`nova_jogada`).

Parameters:
- N_BOTOES, 4, number of buttons; width of `botoes` and `jogada`.
- DEBOUNCE_CICLOS, 50000, consecutive stable cycles needed to accept a press or a release; legal range ≥2.
- W_CONT, 16, debounce counter width; must hold DEBOUNCE_CICLOS.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- botoes  in  N_BOTOES  raw asynchronous buttons, 1 = pressed
- habilita  in  1  play window open
- zera_jogada  in  1  synchronous clear of `jogada` register
- jogada  out  N_BOTOES  last accepted play, one-hot, held until next accept or clear
- jogada_feita  out  1  one-cycle strobe, new play accepted
- jogada_invalida  out  1  one-cycle strobe, debounced press had >1 button
- botao_ativo  out  1  some synchronised button currently pressed
- db_estado  out  3  current FSM state code

Behaviour:
- Reset (reset=0 at an edge): state OCIOSO, counter 0, sync flops 0, jogada=0, jogada_feita=0, jogada_invalida=0. Reset dominates everything, including mid-debounce.
- Sync: 2-flop synchroniser per bit; FSM sees only sync output `s`. Edge k samples a new raw value; `s` shows it after edge k+1.
- States/codes: OCIOSO=0, DEBOUNCE=1, ACEITA=2, INVALIDA=3, ESPERA_SOLTAR=4, DEBOUNCE_SOLTAR=5.
- OCIOSO:
  - s≠0 and habilita=1 → DEBOUNCE; capture s into `cap`; counter=1.
  - s≠0 and habilita=0 → ESPERA_SOLTAR. A press begun outside the window is never accepted.
  - Otherwise stay.
- DEBOUNCE:
  - habilita=0 → OCIOSO (abort).
  - s=0 → OCIOSO.
  - s≠cap, nonzero → recapture; counter=1.
  - s=cap and counter=DEBOUNCE_CICLOS → ACEITA if cap is one-hot, else INVALIDA.
  - Otherwise counter+1.
- ACEITA: jogada_feita=1 for exactly this cycle. The `jogada` register is loaded with cap at the edge entering ACEITA. Unconditional → ESPERA_SOLTAR.
- INVALIDA: jogada_invalida=1 for this cycle; `jogada` unchanged → ESPERA_SOLTAR.
- ESPERA_SOLTAR: s=0 → DEBOUNCE_SOLTAR with counter=1; else stay. Ignores habilita.
- DEBOUNCE_SOLTAR:
  - s≠0 → ESPERA_SOLTAR.
  - counter=DEBOUNCE_CICLOS → OCIOSO.
  - Otherwise counter+1.
- Latency: a clean press first sampled at edge k enters ACEITA at edge k+DEBOUNCE_CICLOS+2. jogada_feita is high in the following cycle. At most one strobe per physical press.
- zera_jogada=1 clears `jogada` at the next edge. If the same edge enters ACEITA, the load wins.
- botao_ativo = (s≠0), combinational from sync flops.
- Counter saturates and never wraps; comparisons are equality on W_CONT bits.
- Outputs are Moore, decoded from state, except the `jogada` register and botao_ativo.

Test Plan (DEBOUNCE_CICLOS=4):
- Reset: hold reset=0 with botoes=4'b0010 for 3 cycles → jogada=0, no strobes, db_estado=0. Release reset → normal operation.
- Clean press: habilita=1, botoes 0→4'b0100 sampled at edge 10, held 20 cycles → jogada_feita high only in the cycle after edge 16; jogada=4'b0100 from then; single strobe. Release → db_estado passes 4→5→0.
- Bounce: botoes=4'b0001 toggling every 2 cycles for 10 cycles, then stable → no strobe during toggling; exactly one strobe 6 cycles after the last stable sample begins.
- Multi-button: botoes=4'b0011 stable, habilita=1 → jogada_invalida one cycle, jogada_feita never, jogada keeps previous value 4'b0100.
- Window: press 4'b1000 with habilita=0, raise habilita while held → no strobe until release plus new press. Drop habilita mid-DEBOUNCE → return to OCIOSO, no strobe.
- Clear/collision: assert zera_jogada alone → jogada=0 next cycle. Assert it on the edge entering ACEITA → jogada holds the new code.
